// File: rtl/i2s_master_clkgen.sv
// I2S master clock sequencer: derives BCK/LRCK from the system clock
// and starts/stops only on frame boundaries.
module i2s_master_clkgen #(
  parameter int DIV_W  = 8,
  parameter int SLOT_W = 6
) (
  input  logic              iSysClk,
  input  logic              iRst_n,
  input  logic              iEnable,
  input  logic [DIV_W-1:0]  iHalfDiv,
  input  logic [SLOT_W-1:0] iSlotBits,
  output logic              oBCK,
  output logic              oLRCK,
  output logic [SLOT_W-1:0] oBitCnt,
  output logic              oFrameStart,
  output logic              oSlotDone,
  output logic              oSlotChan,
  output logic              oBusy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t            state, state_n;
  logic [DIV_W-1:0]  div, div_n;
  logic [DIV_W-1:0]  hsh, hsh_n;
  logic [SLOT_W-1:0] ssh, ssh_n;
  logic [SLOT_W-1:0] bitc, bitc_n;
  logic              bck, bck_n;
  logic              lrck, lrck_n;
  logic              fs, fs_n;
  logic              sd, sd_n;
  logic              chan, chan_n;
  logic              busy, busy_n;
  logic [DIV_W-1:0]  h_in;
  logic [SLOT_W-1:0] s_in;

  always_comb begin
    h_in = (iHalfDiv == '0) ? DIV_W'(1) : iHalfDiv;
    if (iSlotBits < SLOT_W'(8))
      s_in = SLOT_W'(8);
    else if (iSlotBits > SLOT_W'(32))
      s_in = SLOT_W'(32);
    else
      s_in = iSlotBits;
  end

  always_ff @(posedge iSysClk) begin
    if (!iRst_n) begin
      state <= IDLE;
      div   <= '0;
      hsh   <= '0;
      ssh   <= '0;
      bitc  <= '0;
      bck   <= 1'b0;
      lrck  <= 1'b1;
      fs    <= 1'b0;
      sd    <= 1'b0;
      chan  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      div   <= div_n;
      hsh   <= hsh_n;
      ssh   <= ssh_n;
      bitc  <= bitc_n;
      bck   <= bck_n;
      lrck  <= lrck_n;
      fs    <= fs_n;
      sd    <= sd_n;
      chan  <= chan_n;
      busy  <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div;
    hsh_n   = hsh;
    ssh_n   = ssh;
    bitc_n  = bitc;
    bck_n   = bck;
    lrck_n  = lrck;
    fs_n    = 1'b0;
    sd_n    = 1'b0;
    chan_n  = chan;
    busy_n  = busy;
    unique case (state)
      IDLE: begin
        bck_n  = 1'b0;
        lrck_n = 1'b1;
        bitc_n = '0;
        div_n  = '0;
        busy_n = 1'b0;
        if (iEnable) begin
          hsh_n   = h_in;
          ssh_n   = s_in;
          lrck_n  = 1'b0;
          fs_n    = 1'b1;
          busy_n  = 1'b1;
          state_n = RUN;
        end
      end
      RUN, STOPPING: begin
        busy_n  = 1'b1;
        state_n = iEnable ? RUN : STOPPING;
        if (div == hsh - DIV_W'(1)) begin
          div_n = '0;
          bck_n = ~bck;
          // Slot bookkeeping happens only on the BCK falling edge
          if (bck) begin
            if (bitc == ssh - SLOT_W'(1)) begin
              bitc_n = '0;
              sd_n   = 1'b1;
              chan_n = lrck;
              lrck_n = ~lrck;
              if (lrck) begin
                if (state == STOPPING && !iEnable) begin
                  state_n = IDLE;
                  lrck_n  = 1'b1;
                  bck_n   = 1'b0;
                  busy_n  = 1'b0;
                end else begin
                  fs_n  = 1'b1;
                  hsh_n = h_in;
                  ssh_n = s_in;
                end
              end
            end else begin
              bitc_n = bitc + SLOT_W'(1);
            end
          end
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign oBCK        = bck;
  assign oLRCK       = lrck;
  assign oBitCnt     = bitc;
  assign oFrameStart = fs;
  assign oSlotDone   = sd;
  assign oSlotChan   = chan;
  assign oBusy       = busy;

endmodule
